// File: rtl/aemb2_iline_refill_if.sv
// Port bundle for the AEMB2 I-cache line refill controller: requester side,
// Wishbone instruction bus, and the data/tag RAM write ports.
interface aemb2_iline_refill_if #(
  parameter int AW = 30,
  parameter int DW = 32,
  parameter int IW = 6,
  parameter int LW = 2
);
  logic                  miss_i;
  logic [AW-1:0]         miss_adr_i;
  logic                  flush_i;
  logic                  busy_o;
  logic                  done_o;

  logic [AW-1:0]         iwb_adr_o;
  logic                  iwb_cyc_o;
  logic                  iwb_stb_o;
  logic                  iwb_ack_i;
  logic [DW-1:0]         iwb_dat_i;

  logic [IW+LW-1:0]      dwr_adr_o;
  logic [DW-1:0]         dwr_dat_o;
  logic                  dwr_wre_o;
  logic [IW-1:0]         twr_adr_o;
  logic [AW-IW-LW:0]     twr_dat_o;
  logic                  twr_wre_o;

  modport master (
    input  miss_i, miss_adr_i, flush_i, iwb_ack_i, iwb_dat_i,
    output busy_o, done_o, iwb_adr_o, iwb_cyc_o, iwb_stb_o,
           dwr_adr_o, dwr_dat_o, dwr_wre_o, twr_adr_o, twr_dat_o, twr_wre_o
  );

  modport slave (
    output miss_i, miss_adr_i, flush_i, iwb_ack_i, iwb_dat_i,
    input  busy_o, done_o, iwb_adr_o, iwb_cyc_o, iwb_stb_o,
           dwr_adr_o, dwr_dat_o, dwr_wre_o, twr_adr_o, twr_dat_o, twr_wre_o
  );
endinterface

// File: rtl/aemb2_iline_refill.sv
// AEMB2 I-cache refill/invalidate controller: fetches one aligned line over
// Wishbone into the data RAM, then writes {valid,tag}; sweeps tags on reset/flush.
module aemb2_iline_refill #(
  parameter int AW = 30,
  parameter int DW = 32,
  parameter int IW = 6,
  parameter int LW = 2
) (
  input logic                  clk_i,
  input logic                  rst_i,
  aemb2_iline_refill_if.master bus
);

  localparam int TW = AW - IW - LW;
  localparam logic [AW-1:0] OFS_MASK = AW'((1 << LW) - 1);

  typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_FILL, S_TAG} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     fcnt_q, fcnt_d;
  logic [LW-1:0]     wcnt_q, wcnt_d, wcnt_inc;
  logic [IW-1:0]     idx_q, idx_d;
  logic [TW-1:0]     tag_q, tag_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cyc_q, cyc_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [IW+LW-1:0]  dwr_adr_q, dwr_adr_d;
  logic [DW-1:0]     dwr_dat_q, dwr_dat_d;
  logic              dwr_wre_q, dwr_wre_d;
  logic [IW-1:0]     twr_adr_q, twr_adr_d;
  logic [TW:0]       twr_dat_q, twr_dat_d;
  logic              twr_wre_q, twr_wre_d;

  assign wcnt_inc = wcnt_q + LW'(1);

  // Every output is computed one state ahead and registered, so nothing
  // combinational reaches the ports.
  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    wcnt_d    = wcnt_q;
    idx_d     = idx_q;
    tag_d     = tag_q;
    cyc_d     = cyc_q;
    adr_d     = adr_q;
    dwr_adr_d = dwr_adr_q;
    dwr_dat_d = dwr_dat_q;
    dwr_wre_d = 1'b0;
    twr_adr_d = twr_adr_q;
    twr_dat_d = twr_dat_q;
    twr_wre_d = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_FLUSH: begin
        twr_wre_d = 1'b1;
        twr_adr_d = fcnt_q;
        twr_dat_d = '0;
        fcnt_d    = fcnt_q + IW'(1);
        if (fcnt_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.flush_i) begin
          state_d = S_FLUSH;
          fcnt_d  = '0;
        end else if (bus.miss_i) begin
          tag_d   = bus.miss_adr_i[AW-1:IW+LW];
          idx_d   = bus.miss_adr_i[IW+LW-1:LW];
          wcnt_d  = '0;
          adr_d   = bus.miss_adr_i & ~OFS_MASK;
          cyc_d   = 1'b1;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (bus.iwb_ack_i) begin
          dwr_wre_d = 1'b1;
          dwr_adr_d = {idx_q, wcnt_q};
          dwr_dat_d = bus.iwb_dat_i;
          wcnt_d    = wcnt_inc;
          // Only the word offset advances; the line base stays fixed.
          adr_d     = (adr_q & ~OFS_MASK) | AW'(wcnt_inc);
          if (wcnt_q == '1) begin
            cyc_d   = 1'b0;
            state_d = S_TAG;
          end
        end
      end
      S_TAG: begin
        twr_wre_d = 1'b1;
        twr_adr_d = idx_q;
        twr_dat_d = {1'b1, tag_q};
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_FLUSH;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FLUSH;
      fcnt_q    <= '0;
      wcnt_q    <= '0;
      idx_q     <= '0;
      tag_q     <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      cyc_q     <= 1'b0;
      adr_q     <= '0;
      dwr_adr_q <= '0;
      dwr_dat_q <= '0;
      dwr_wre_q <= 1'b0;
      twr_adr_q <= '0;
      twr_dat_q <= '0;
      twr_wre_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      wcnt_q    <= wcnt_d;
      idx_q     <= idx_d;
      tag_q     <= tag_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cyc_q     <= cyc_d;
      adr_q     <= adr_d;
      dwr_adr_q <= dwr_adr_d;
      dwr_dat_q <= dwr_dat_d;
      dwr_wre_q <= dwr_wre_d;
      twr_adr_q <= twr_adr_d;
      twr_dat_q <= twr_dat_d;
      twr_wre_q <= twr_wre_d;
    end
  end

  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.iwb_adr_o = adr_q;
  assign bus.iwb_cyc_o = cyc_q;
  assign bus.iwb_stb_o = cyc_q;
  assign bus.dwr_adr_o = dwr_adr_q;
  assign bus.dwr_dat_o = dwr_dat_q;
  assign bus.dwr_wre_o = dwr_wre_q;
  assign bus.twr_adr_o = twr_adr_q;
  assign bus.twr_dat_o = twr_dat_q;
  assign bus.twr_wre_o = twr_wre_q;

endmodule
